// File: rtl/xbus_arb2.sv
// Two-master arbiter in front of a single-port xbus slave with synchronous read.
// Define XARB_RR_EN for round-robin arbitration; otherwise m1 (data) has fixed priority.

`ifndef XBYTEC
`define XBYTEC 4
`endif
`ifndef XADDRW
`define XADDRW 32
`endif
`ifndef XDATAW
`define XDATAW 32
`endif

module xbus_arb2 #(
    parameter int LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [`XBYTEC-1:0]   m0_be,
    input  logic [`XADDRW-1:0]   m0_addr,
    input  logic [`XDATAW-1:0]   m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    output logic [`XDATAW-1:0]   m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [`XBYTEC-1:0]   m1_be,
    input  logic [`XADDRW-1:0]   m1_addr,
    input  logic [`XDATAW-1:0]   m1_wdata,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [`XDATAW-1:0]   m1_rdata,
    output logic                 xbus_cs,
    output logic                 xbus_we,
    output logic [`XBYTEC-1:0]   xbus_be,
    output logic [`XADDRW-1:0]   xbus_addr,
    output logic [`XDATAW-1:0]   xbus_wdata,
    input  logic [`XDATAW-1:0]   xbus_rdata
);

    logic           r_last;
    logic [LAT-1:0] r_pipe_vld;
    logic [LAT-1:0] r_pipe_own;

    logic           w_sel;
    logic           w_grant;
    logic           w_rd;

    // Winner selection: w_sel is the winning master id (0 when nobody requests).
    always_comb begin
        w_sel = 1'b0;
`ifdef XARB_RR_EN
        if (m0_req && m1_req) begin
            w_sel = ~r_last;
        end else begin
            w_sel = m1_req;
        end
`else
        if (m1_req) begin
            w_sel = 1'b1;
        end else begin
            w_sel = 1'b0;
        end
`endif
    end

    assign w_grant = (m0_req || m1_req) && !rst;
    assign w_rd    = w_grant && !xbus_we;

    // Slave bus mux; payload defaults to m0 when idle.
    always_comb begin
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        xbus_cs    = w_grant;
        xbus_we    = 1'b0;
        xbus_be    = m0_be;
        xbus_addr  = m0_addr;
        xbus_wdata = m0_wdata;
        if (w_sel) begin
            m1_gnt     = w_grant;
            xbus_we    = w_grant && m1_we;
            xbus_be    = m1_be;
            xbus_addr  = m1_addr;
            xbus_wdata = m1_wdata;
        end else begin
            m0_gnt     = w_grant;
            xbus_we    = w_grant && m0_we;
        end
    end

    // Response tag pipeline and most-recent-winner register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_own <= '0;
            r_last     <= 1'b1;
        end else begin
            r_pipe_vld[0] <= w_rd;
            r_pipe_own[0] <= w_sel;
            for (int i = 1; i < LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_own[i] <= r_pipe_own[i-1];
            end
            if (w_grant) begin
                r_last <= w_sel;
            end else begin
                r_last <= r_last;
            end
        end
    end

    // Final pipeline stage steers the one-cycle rvalid to the owning master.
    always_comb begin
        m0_rvalid = r_pipe_vld[LAT-1] && !r_pipe_own[LAT-1] && !rst;
        m1_rvalid = r_pipe_vld[LAT-1] &&  r_pipe_own[LAT-1] && !rst;
        m0_rdata  = xbus_rdata;
        m1_rdata  = xbus_rdata;
    end

endmodule

// File: tb/tb_xbus_arb2.sv
// Directed self-checking bench for xbus_arb2: three instances with LAT=1,2,3
// sharing one clock, each with its own behavioural slave memory.

`ifndef XBYTEC
`define XBYTEC 4
`endif
`ifndef XADDRW
`define XADDRW 32
`endif
`ifndef XDATAW
`define XDATAW 32
`endif

module tb_xbus_arb2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst       [3];
    logic               m0_req    [3];
    logic               m0_we     [3];
    logic [`XBYTEC-1:0] m0_be     [3];
    logic [`XADDRW-1:0] m0_addr   [3];
    logic [`XDATAW-1:0] m0_wdata  [3];
    logic               m0_gnt    [3];
    logic               m0_rvalid [3];
    logic [`XDATAW-1:0] m0_rdata  [3];
    logic               m1_req    [3];
    logic               m1_we     [3];
    logic [`XBYTEC-1:0] m1_be     [3];
    logic [`XADDRW-1:0] m1_addr   [3];
    logic [`XDATAW-1:0] m1_wdata  [3];
    logic               m1_gnt    [3];
    logic               m1_rvalid [3];
    logic [`XDATAW-1:0] m1_rdata  [3];
    logic               xbus_cs   [3];
    logic               xbus_we   [3];
    logic [`XBYTEC-1:0] xbus_be   [3];
    logic [`XADDRW-1:0] xbus_addr [3];
    logic [`XDATAW-1:0] xbus_wdata[3];
    logic [`XDATAW-1:0] xbus_rdata[3];

    logic [`XDATAW-1:0] mem   [3][64];
    logic [`XDATAW-1:0] rpipe [3][4];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        xbus_arb2 #(.LAT(g + 1)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .m0_req     (m0_req[g]),
            .m0_we      (m0_we[g]),
            .m0_be      (m0_be[g]),
            .m0_addr    (m0_addr[g]),
            .m0_wdata   (m0_wdata[g]),
            .m0_gnt     (m0_gnt[g]),
            .m0_rvalid  (m0_rvalid[g]),
            .m0_rdata   (m0_rdata[g]),
            .m1_req     (m1_req[g]),
            .m1_we      (m1_we[g]),
            .m1_be      (m1_be[g]),
            .m1_addr    (m1_addr[g]),
            .m1_wdata   (m1_wdata[g]),
            .m1_gnt     (m1_gnt[g]),
            .m1_rvalid  (m1_rvalid[g]),
            .m1_rdata   (m1_rdata[g]),
            .xbus_cs    (xbus_cs[g]),
            .xbus_we    (xbus_we[g]),
            .xbus_be    (xbus_be[g]),
            .xbus_addr  (xbus_addr[g]),
            .xbus_wdata (xbus_wdata[g]),
            .xbus_rdata (xbus_rdata[g])
        );
    end

    // Slave model: byte-enabled write, read data valid LAT cycles after cs.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (xbus_cs[d] && xbus_we[d]) begin
                for (int b = 0; b < 4; b++) begin
                    if (xbus_be[d][b]) mem[d][xbus_addr[d][7:2]][8*b +: 8] <= xbus_wdata[d][8*b +: 8];
                end
            end
            rpipe[d][0] <= (xbus_cs[d] && !xbus_we[d]) ? mem[d][xbus_addr[d][7:2]] : 32'h0;
            for (int k = 1; k < 4; k++) rpipe[d][k] <= rpipe[d][k-1];
        end
    end

    always_comb begin
        for (int d = 0; d < 3; d++) xbus_rdata[d] = rpipe[d][d];
    end

    function automatic logic [31:0] memval(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        m0_req[d] = 1'b0; m0_we[d] = 1'b0; m0_be[d] = 4'hF; m0_addr[d] = 32'h0; m0_wdata[d] = 32'h0;
        m1_req[d] = 1'b0; m1_we[d] = 1'b0; m1_be[d] = 4'hF; m1_addr[d] = 32'h0; m1_wdata[d] = 32'h0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            idle(d);
            rst[d] = 1'b1;
        end
        tick();
        m0_req[0] = 1'b1;
        m1_req[0] = 1'b1;
        #1;
        checks++;
        if (m0_gnt[0] !== 1'b0 || m1_gnt[0] !== 1'b0 || xbus_cs[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_gnt got m0_gnt=%b m1_gnt=%b cs=%b want 0 0 0", m0_gnt[0], m1_gnt[0], xbus_cs[0]);
        end
        tick();
        idle(0);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (m0_rvalid[d] !== 1'b0 || m1_rvalid[d] !== 1'b0 || xbus_cs[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle dut%0d got rv0=%b rv1=%b cs=%b want 0 0 0", d, m0_rvalid[d], m1_rvalid[d], xbus_cs[d]);
            end
        end
    endtask

    task automatic test_single_read();
        tick();
        m0_req[0] = 1'b1; m0_addr[0] = 32'h10;
        #1;
        checks++;
        if (m0_gnt[0] !== 1'b1 || xbus_addr[0] !== 32'h10 || m1_rvalid[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_gnt got gnt=%b addr=%h rv1=%b want 1 00000010 0", m0_gnt[0], xbus_addr[0], m1_rvalid[0]);
        end
        tick();
        m0_req[0] = 1'b0;
        #1;
        checks++;
        if (m0_rvalid[0] !== 1'b1 || m0_rdata[0] !== 32'hDEADBEEF || m1_rvalid[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_rdata got rv=%b data=%h rv1=%b want 1 deadbeef 0", m0_rvalid[0], m0_rdata[0], m1_rvalid[0]);
        end
        tick();
        #1;
        checks++;
        if (m0_rvalid[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse got rv=%b want 0", m0_rvalid[0]);
        end
    endtask

    // m0 was the most recent winner, so m1 wins first in either arbitration mode.
    task automatic test_contention();
        tick();
        m0_req[0] = 1'b1; m0_addr[0] = 32'h0;
        m1_req[0] = 1'b1; m1_addr[0] = 32'h4;
        #1;
        checks++;
        if (m1_gnt[0] !== 1'b1 || m0_gnt[0] !== 1'b0 || xbus_addr[0] !== 32'h4) begin
            failures++;
            $display("FAIL cont_c0 got g0=%b g1=%b addr=%h want 0 1 00000004", m0_gnt[0], m1_gnt[0], xbus_addr[0]);
        end
        tick();
        m1_req[0] = 1'b0;
        #1;
        checks++;
        if (m0_gnt[0] !== 1'b1 || m1_rvalid[0] !== 1'b1 || m1_rdata[0] !== memval(1) || m0_rvalid[0] !== 1'b0) begin
            failures++;
            $display("FAIL cont_c1 got g0=%b rv1=%b d=%h rv0=%b want 1 1 %h 0", m0_gnt[0], m1_rvalid[0], m1_rdata[0], m0_rvalid[0], memval(1));
        end
        tick();
        m0_req[0] = 1'b0;
        #1;
        checks++;
        if (m0_rvalid[0] !== 1'b1 || m0_rdata[0] !== memval(0) || m1_rvalid[0] !== 1'b0) begin
            failures++;
            $display("FAIL cont_c2 got rv0=%b d=%h rv1=%b want 1 %h 0", m0_rvalid[0], m0_rdata[0], m1_rvalid[0], memval(0));
        end
    endtask

    task automatic test_write_read();
        tick();
        m1_req[0] = 1'b1; m1_we[0] = 1'b1; m1_be[0] = 4'hF; m1_addr[0] = 32'h20; m1_wdata[0] = 32'hA5A5A5A5;
        #1;
        checks++;
        if (m1_gnt[0] !== 1'b1 || xbus_we[0] !== 1'b1 || xbus_wdata[0] !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL wr_gnt got g1=%b we=%b wd=%h want 1 1 a5a5a5a5", m1_gnt[0], xbus_we[0], xbus_wdata[0]);
        end
        tick();
        m1_we[0] = 1'b0;
        #1;
        checks++;
        if (m1_gnt[0] !== 1'b1 || m1_rvalid[0] !== 1'b0 || xbus_we[0] !== 1'b0) begin
            failures++;
            $display("FAIL rd_after_wr got g1=%b rv1=%b we=%b want 1 0 0", m1_gnt[0], m1_rvalid[0], xbus_we[0]);
        end
        tick();
        m1_req[0] = 1'b0;
        #1;
        checks++;
        if (m1_rvalid[0] !== 1'b1 || m1_rdata[0] !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL wr_rd_data got rv1=%b d=%h want 1 a5a5a5a5", m1_rvalid[0], m1_rdata[0]);
        end
    endtask

    // LAT=2 instance, fresh from reset, both masters requesting for six cycles.
    task automatic test_arbitration();
        logic own [6];
        logic e_g0, e_rv0, e_rv1;
        for (int k = 0; k < 6; k++) begin
`ifdef XARB_RR_EN
            own[k] = (k % 2 == 1);
`else
            own[k] = 1'b1;
`endif
        end
        for (int c = 0; c < 9; c++) begin
            tick();
            m0_req[1] = (c < 6); m0_addr[1] = 32'h0;
            m1_req[1] = (c < 6); m1_addr[1] = 32'h4;
            #1;
            e_g0  = (c < 6) && !own[c % 6];
            e_rv0 = (c >= 2) && (c < 8) && !own[(c + 4) % 6];
            e_rv1 = (c >= 2) && (c < 8) &&  own[(c + 4) % 6];
            checks++;
            if (m0_gnt[1] !== e_g0 || m1_gnt[1] !== ((c < 6) && !e_g0) || xbus_cs[1] !== (c < 6)) begin
                failures++;
                $display("FAIL arb_gnt c%0d got g0=%b g1=%b cs=%b want %b %b %b", c, m0_gnt[1], m1_gnt[1], xbus_cs[1],
                         e_g0, (c < 6) && !e_g0, c < 6);
            end
            checks++;
            if (m0_rvalid[1] !== e_rv0 || m1_rvalid[1] !== e_rv1 ||
                ((e_rv0 || e_rv1) && xbus_rdata[1] !== memval(e_rv1 ? 1 : 0))) begin
                failures++;
                $display("FAIL arb_rv c%0d got rv0=%b rv1=%b d=%h want %b %b", c, m0_rvalid[1], m1_rvalid[1], xbus_rdata[1], e_rv0, e_rv1);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 7; c++) begin
            tick();
            m0_req[2]  = (c < 3);
            m0_addr[2] = 32'(4 * c);
            #1;
            checks++;
            if (m0_gnt[2] !== (c < 3) || m0_rvalid[2] !== (c >= 3 && c < 6) || m1_rvalid[2] !== 1'b0 ||
                ((c >= 3 && c < 6) && m0_rdata[2] !== memval(c - 3))) begin
                failures++;
                $display("FAIL b2b c%0d got g0=%b rv0=%b rv1=%b d=%h want %b %b 0 %h", c, m0_gnt[2], m0_rvalid[2], m1_rvalid[2],
                         m0_rdata[2], c < 3, c >= 3 && c < 6, memval(c - 3));
            end
        end
    endtask

    task automatic test_reset_midflight();
        tick();
        idle(1);
        m0_req[1] = 1'b1;
        #1;
        checks++;
        if (m0_gnt[1] !== 1'b1) begin
            failures++;
            $display("FAIL mid_gnt got g0=%b want 1", m0_gnt[1]);
        end
        tick();
        rst[1] = 1'b1; m0_req[1] = 1'b0; m1_req[1] = 1'b1;
        #1;
        checks++;
        if (m1_gnt[1] !== 1'b0 || xbus_cs[1] !== 1'b0 || m0_rvalid[1] !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst got g1=%b cs=%b rv0=%b want 0 0 0", m1_gnt[1], xbus_cs[1], m0_rvalid[1]);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            rst[1] = 1'b0; m1_req[1] = 1'b0;
            #1;
            checks++;
            if (m0_rvalid[1] !== 1'b0 || m1_rvalid[1] !== 1'b0) begin
                failures++;
                $display("FAIL mid_norv c%0d got rv0=%b rv1=%b want 0 0", c, m0_rvalid[1], m1_rvalid[1]);
            end
        end
        tick();
        m0_req[1] = 1'b1; m1_req[1] = 1'b1;
        #1;
        checks++;
`ifdef XARB_RR_EN
        if (m0_gnt[1] !== 1'b1 || m1_gnt[1] !== 1'b0) begin
            failures++;
            $display("FAIL mid_first got g0=%b g1=%b want 1 0", m0_gnt[1], m1_gnt[1]);
        end
`else
        if (m0_gnt[1] !== 1'b0 || m1_gnt[1] !== 1'b1) begin
            failures++;
            $display("FAIL mid_first got g0=%b g1=%b want 0 1", m0_gnt[1], m1_gnt[1]);
        end
`endif
        tick();
        idle(1);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 64; i++) mem[d][i] <= memval(i);
            for (int k = 0; k < 4; k++) rpipe[d][k] <= 32'h0;
        end
        mem[0][4] <= 32'hDEADBEEF;
        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_arbitration();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xbus_arb2.md
Name: xbus_arb2

Overview:
- Two-master arbiter in front of one shared single-port xbus slave (ROM/RAM with synchronous read).
- Master 0 is instruction fetch; master 1 is data load/store.
- Grants at most one access per cycle and drives the slave xbus from the winner.
- Routes read data back to the issuing master with a tagged response pipeline matched to the slave's read latency.

Parameters:
- LAT, 1, slave read latency in cycles from cs-high to rdata valid; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  master 0 access request
- m0_we  in  1  master 0 write enable
- m0_be  in  `XBYTEC  master 0 byte enables
- m0_addr  in  `XADDRW  master 0 byte address
- m0_wdata  in  `XDATAW  master 0 write data
- m0_gnt  out  1  master 0 request accepted this cycle
- m0_rvalid  out  1  master 0 read data valid
- m0_rdata  out  `XDATAW  master 0 read data
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0
- xbus_cs  out  1  slave select
- xbus_we  out  1  slave write enable
- xbus_be  out  `XBYTEC  slave byte enables
- xbus_addr  out  `XADDRW  slave address
- xbus_wdata  out  `XDATAW  slave write data
- xbus_rdata  in  `XDATAW  slave read data

Behaviour:
- Widths come from `XBYTEC, `XADDRW and `XDATAW in config.vh.
- Arbitration is combinational in the request cycle.
  - Winner gets gnt=1 in the same cycle.
  - Slave bus carries the winner's we/be/addr/wdata with xbus_cs=1.
  - Loser gets gnt=0 and must hold its request and payload until granted.
- No request: xbus_cs=0, xbus_we=0, and both gnt=0. addr/be/wdata are don't-care but are driven from m0.
- Master contract: req may drop only after gnt. Requests may be issued back-to-back; one access per cycle, full throughput.
- Response pipeline: LAT-stage shift register of {valid, owner}.
  - Stage 0 loads {granted && !we, winner_id}.
  - When the final stage is valid, it asserts rvalid for the owning master only, for exactly one cycle, LAT cycles after gnt.
- Read data routing: m0_rdata and m1_rdata both equal xbus_rdata combinationally. Masters sample only when their own rvalid is high.
- Writes produce no rvalid. gnt is the write completion.
- Responses return strictly in grant order. A write followed by a read to the same address in the next cycle returns the new data, because slave ordering is preserved.
- Priority register `last` (1 bit) holds the id of the most recent winner. It updates on every grant and is used only when XARB_RR_EN is defined.
- Reset (synchronous, rst=1 at posedge):
  - Clears all pipeline valid bits and sets `last`=1, so m0 wins first under round-robin.
  - In-flight reads are discarded and no rvalid is produced after reset.
  - While rst=1: gnt=0, xbus_cs=0, rvalid=0.
- Boundaries:
  - Both masters requesting on every cycle gives 100% slave utilisation.
  - A read granted in the cycle rst asserts never returns rvalid.
  - One master requesting alone is granted every cycle regardless of `last`.

Optional Feature:
- XARB_RR_EN defined: round-robin arbitration.
  - On a simultaneous request, the master that is not `last` wins.
  - Both masters requesting continuously alternate m0, m1, m0, ...
- XARB_RR_EN undefined: fixed priority, m1 (data) always beats m0.
  - `last` is still maintained but unused.
  - m0 can starve while m1 requests continuously.

Test Plan:
- Single read, LAT=1: m0_req, addr=0x10 with slave mem[4]=0xDEADBEEF -> m0_gnt=1 and xbus_addr=0x10 in cycle 0; m0_rvalid=1 and m0_rdata=0xDEADBEEF in cycle 1; m1_rvalid=0 throughout.
- Contention, fixed priority: m0 reads 0x0 and m1 reads 0x4 simultaneously -> m1_gnt in cycle 0, m0_gnt in cycle 1; m1_rvalid in cycle 1, m0_rvalid in cycle 2; data mem[1] then mem[0].
- Contention with XARB_RR_EN, both requesting for 6 cycles after reset -> grant sequence m0, m1, m0, m1, m0, m1; each rvalid follows its gnt by exactly LAT.
- Write/read ordering: m1 writes 0xA5A5A5A5 to 0x20 with be=4'hF, then m1 reads 0x20 the next cycle -> no rvalid for the write; the read returns 0xA5A5A5A5.
- LAT=3: back-to-back reads from m0 to 0x0, 0x4, 0x8 -> three consecutive m0_rvalid pulses in cycles 3, 4, 5, in order.
- Reset mid-flight, LAT=2: grant an m0 read, assert rst on the next cycle -> no m0_rvalid ever appears; after rst deasserts, the first simultaneous request under XARB_RR_EN grants m0.
